finish_test: RTL and testbench



---
 rtl/finish_test_if.sv | 11 +
 rtl/finish_test.sv | 56 +++++
 tb/tb_finish_test.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/finish_test_if.sv
// Status bundle of the terminal-count sequencer: the registered count and
// the sticky done flag, driven by the sequencer and observed by the bench.
interface finish_test_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] count;
  logic             done;

  modport master (output count, output done);
  modport slave  (input  count, input  done);
endinterface

// File: rtl/finish_test.sv
// Terminal-count sequencer: counts cycles after reset, raises a sticky done
// flag and freezes the count once TERMINAL is reached.
module finish_test #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 10
) (
  input  logic          clk,
  input  logic          rst,
  finish_test_if.master bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TERM_M1 = WIDTH'(TERMINAL - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
    end
  end

  // done is the state flop itself, so it rises on the same edge that
  // loads TERMINAL into the counter.
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    case (state)
      S_RUN: begin
        count_nxt = count_q + 1'b1;
        if (count_q == TERM_M1) state_nxt = S_DONE;
      end
      S_DONE: begin
        count_nxt = count_q;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  assign bus.count = count_q;
  assign bus.done  = (state == S_DONE);

endmodule

// File: tb/tb_finish_test.sv
// Directed bench for finish_test: TERMINAL=10 main instance plus
// TERMINAL=1 and TERMINAL=15 corner instances sharing one clock.
module tb_finish_test;

  logic clk;
  logic rst10;
  logic rst1;
  logic rst15;

  int checks;
  int errors;
  int rises10;

  finish_test_if #(.WIDTH(4)) bus10 ();
  finish_test_if #(.WIDTH(4)) bus1 ();
  finish_test_if #(.WIDTH(4)) bus15 ();

  finish_test #(.WIDTH(4), .TERMINAL(10)) dut10 (.clk(clk), .rst(rst10), .bus(bus10));
  finish_test #(.WIDTH(4), .TERMINAL(1))  dut1  (.clk(clk), .rst(rst1),  .bus(bus1));
  finish_test #(.WIDTH(4), .TERMINAL(15)) dut15 (.clk(clk), .rst(rst15), .bus(bus15));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial rises10 = 0;
  always @(posedge bus10.done) rises10 = rises10 + 1;

  task automatic reset10();
    @(negedge clk);
    rst10 = 1'b1;
    @(negedge clk);
    rst10 = 1'b0;
  endtask

  // Cycles from the current negedge until done is seen, bounded.
  task automatic wait_done10(output int cycles);
    cycles = 0;
    while (bus10.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus10.count !== 4'd0 || bus10.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: count=%0d done=%b expected count=0 done=0", bus10.count, bus10.done);
      end
    end
    rst10 = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus10.count !== 4'(i) || bus10.done !== (i == 10)) begin
        errors++;
        $display("FAIL basic_count[%0d] at %0t: count=%0d done=%b expected count=%0d done=%b",
                 i, $time, bus10.count, bus10.done, i, (i == 10));
      end
    end
    checks++;
    if (rises10 !== 1) begin
      errors++;
      $display("FAIL basic_rises: got %0d expected 1", rises10);
    end
  endtask

  task automatic test_hold();
    int r;
    r = rises10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus10.count !== 4'd10 || bus10.done !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: count=%0d done=%b expected count=10 done=1", i, bus10.count, bus10.done);
      end
    end
    checks++;
    if (rises10 !== r) begin
      errors++;
      $display("FAIL hold_rises: got %0d expected %0d", rises10, r);
    end
  endtask

  task automatic test_async_pulse();
    int n;
    reset10();
    repeat (3) @(negedge clk);
    checks++;
    if (bus10.count !== 4'd3) begin
      errors++;
      $display("FAIL pulse_pre: count=%0d expected 3", bus10.count);
    end
    #1 rst10 = 1'b1;
    #2 rst10 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus10.count !== 4'd4 || bus10.done !== 1'b0) begin
      errors++;
      $display("FAIL pulse_count: count=%0d done=%b expected count=4 done=0", bus10.count, bus10.done);
    end
    wait_done10(n);
    #1 rst10 = 1'b1;
    #2 rst10 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus10.count !== 4'd10 || bus10.done !== 1'b1) begin
      errors++;
      $display("FAIL pulse_done: count=%0d done=%b expected count=10 done=1", bus10.count, bus10.done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reset10();
    repeat (6) @(negedge clk);
    checks++;
    if (bus10.count !== 4'd6) begin
      errors++;
      $display("FAIL mid_pre: count=%0d expected 6", bus10.count);
    end
    rst10 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus10.count !== 4'd0 || bus10.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d done=%b expected count=0 done=0", bus10.count, bus10.done);
    end
    rst10 = 1'b0;
    wait_done10(n);
    checks++;
    if (n !== 10 || bus10.count !== 4'd10) begin
      errors++;
      $display("FAIL mid_latency: cycles=%0d count=%0d expected cycles=10 count=10", n, bus10.count);
    end
  endtask

  task automatic test_reset_after_done();
    int n;
    int r;
    r = rises10;
    @(negedge clk);
    rst10 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus10.count !== 4'd0 || bus10.done !== 1'b0) begin
      errors++;
      $display("FAIL done_reset: count=%0d done=%b expected count=0 done=0", bus10.count, bus10.done);
    end
    rst10 = 1'b0;
    wait_done10(n);
    checks++;
    if (n !== 10 || bus10.count !== 4'd10 || rises10 !== r + 1) begin
      errors++;
      $display("FAIL done_rerun: cycles=%0d count=%0d rises=%0d expected cycles=10 count=10 rises=%0d",
               n, bus10.count, rises10, r + 1);
    end
  endtask

  task automatic test_corners();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus1.count !== 4'd0 || bus1.done !== 1'b0 || bus15.count !== 4'd0 || bus15.done !== 1'b0) begin
      errors++;
      $display("FAIL corner_reset: t1 count=%0d done=%b t15 count=%0d done=%b expected all 0",
               bus1.count, bus1.done, bus15.count, bus15.done);
    end
    rst1  = 1'b0;
    rst15 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.count !== 4'd1 || bus1.done !== 1'b1) begin
        errors++;
        $display("FAIL t1[%0d]: count=%0d done=%b expected count=1 done=1", i, bus1.count, bus1.done);
      end
      checks++;
      if (bus15.count !== 4'((i < 15) ? i : 15) || bus15.done !== (i >= 15)) begin
        errors++;
        $display("FAIL t15[%0d]: count=%0d done=%b expected count=%0d done=%b",
                 i, bus15.count, bus15.done, (i < 15) ? i : 15, (i >= 15));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst10  = 1'b1;
    rst1   = 1'b1;
    rst15  = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_reset_after_done();
    test_reset_mid();
    test_async_pulse();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
